// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared definitions for the booth product accumulator slice.
//   PROD_W : width of the signed product stream from booth_multiplier
//   ACC_W  : width of the signed accumulator / result (must exceed PROD_W)
//   CNT_W  : width of the saturating term counter
//   acc_state_t : accumulator FSM states (ACCUM collects terms, HOLD presents a result)
package booth_pkg;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/booth_product_accumulator_sat_add.sv
// booth_sat_add
//   Combinational signed add of a sign-extended product term to the running
//   accumulator, with signed-overflow detection.
//   Build option: BOOTH_ACC_SATURATE_EN -- when defined, an overflowing sum is
//   clamped to the most positive / most negative ACC_W value; otherwise the
//   sum wraps modulo 2^ACC_W. The overflow flag is the same in both builds.
//   Ports:
//     acc     (in,  ACC_W)  : current accumulator value (two's complement)
//     product (in,  PROD_W) : signed product term
//     sum     (out, ACC_W)  : acc + sext(product), wrapped or clamped
//     ovf     (out, 1)      : signed overflow occurred on this add
module booth_sat_add
  import booth_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] raw_sum;

  // Sign extension: low bits pass through, upper bits replicate the product sign.
  assign prod_ext[PROD_W-1:0] = product;

  generate
    for (genvar gi = PROD_W; gi < ACC_W; gi++) begin : g_sext
      assign prod_ext[gi] = product[PROD_W-1];
    end
  endgenerate

  assign raw_sum = acc + prod_ext;

  // Overflow only possible when both operands share a sign and the result flips it.
  assign ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (raw_sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // On overflow the operands' common sign tells the direction of the clamp.
  assign sum = ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw_sum;
`else
  assign sum = raw_sum;
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
//   Multiply-accumulate back end for the booth_multiplier product stream.
//   Sums a variable-length vector of signed products (terminated by in_last)
//   and presents one dot-product result per vector over valid/ready.
//   Build option: BOOTH_ACC_SATURATE_EN (see booth_sat_add) selects clamping
//   instead of wrap-around on accumulator overflow.
//   Ports:
//     clk        (in)          : rising-edge clock
//     rst_n      (in)          : asynchronous active-low reset
//     in_valid   (in)          : in_product / in_last valid
//     in_ready   (out)         : term accepted this cycle (high in ACCUM)
//     in_product (in, PROD_W)  : signed product term
//     in_last    (in)          : accepted term closes the vector
//     out_valid  (out)         : result held (high in HOLD)
//     out_ready  (in)          : consumer takes the result
//     out_sum    (out, ACC_W)  : signed accumulated sum
//     out_count  (out, CNT_W)  : accepted term count, saturating
//     out_ovf    (out)         : sticky signed-overflow flag for the vector
module booth_product_accumulator
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  acc_state_t       state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  booth_sat_add u_sat_add (
    .acc     (acc_reg),
    .product (in_product),
    .sum     (add_sum),
    .ovf     (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      ACCUM: begin
        if (in_valid) begin
          acc_next = add_sum;
          // Counter holds at all-ones rather than wrapping on long vectors.
          cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
          ovf_next = ovf_reg | add_ovf;
          if (in_last) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // Clearing on release means the next vector starts from zero with
        // no extra cycle beyond the single bubble.
        if (out_ready) begin
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == HOLD);

  // Result ports expose the registers directly; they show running values in
  // ACCUM and are only meaningful when out_valid is high.
  assign out_sum   = acc_reg;
  assign out_count = cnt_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_product;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int n_checks;
  int n_pass;

  booth_product_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
      $display("check %-16s got 0x%0h exp 0x%0h ok", tag, observed, expected);
    end else begin
      $display("FAIL %-16s got 0x%0h exp 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one term for a single clock edge; DUT is expected to be in ACCUM.
  task automatic send(input logic [15:0] prod, input logic last);
    in_valid   = 1'b1;
    in_product = prod;
    in_last    = last;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(out_sum),   32'd0);
    chk("rst_count",     32'(out_count), 32'd0);
    chk("rst_ovf",       32'(out_ovf),   32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Multi-term vector: 35 + 35 - 35
    send(16'd35, 1'b0);
    send(16'd35, 1'b0);
    chk("mt_valid_early", 32'(out_valid), 32'd0);
    chk("mt_running_sum", 32'(out_sum),   32'd70);
    send(-16'sd35, 1'b1);
    chk("mt_valid",       32'(out_valid), 32'd1);
    chk("mt_in_ready",    32'(in_ready),  32'd0);
    chk("mt_sum",         32'(out_sum),   32'd35);
    chk("mt_count",       32'(out_count), 32'd3);
    chk("mt_ovf",         32'(out_ovf),   32'd0);
    release_result();
    chk("mt_rel_ready",   32'(in_ready),  32'd1);
    chk("mt_rel_count",   32'(out_count), 32'd0);

    // Single-term vector
    send(-16'sd49, 1'b1);
    chk("st_valid", 32'(out_valid), 32'd1);
    chk("st_sum",   32'(out_sum),   32'h00FF_FFCF);
    chk("st_count", 32'(out_count), 32'd1);
    release_result();

    // Backpressure: result must hold and no term absorbed while in HOLD
    send(16'd10, 1'b0);
    send(16'd20, 1'b1);
    in_valid   = 1'b1;
    in_product = 16'd100;
    in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_sum",   32'(out_sum),   32'd30);
    chk("bp_count", 32'(out_count), 32'd2);
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result();
    chk("bp_rel_ready", 32'(in_ready),  32'd1);
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_count", 32'(out_count), 32'd0);
    chk("bp_rel_sum",   32'(out_sum),   32'd0);

    // Overflow: 512 x 16384 = 2^23 exceeds the 24-bit signed range on the last term
    for (int i = 0; i < 511; i++) begin
      send(16'd16384, 1'b0);
    end
    chk("ov_pre_sum",   32'(out_sum),   32'h007F_C000);
    chk("ov_pre_ovf",   32'(out_ovf),   32'd0);
    chk("ov_pre_count", 32'(out_count), 32'd255);
    send(16'd16384, 1'b1);
    chk("ov_valid", 32'(out_valid), 32'd1);
`ifdef BOOTH_ACC_SATURATE_EN
    chk("ov_sum",   32'(out_sum),   32'h007F_FFFF);
`else
    chk("ov_sum",   32'(out_sum),   32'h0080_0000);
`endif
    chk("ov_ovf",   32'(out_ovf),   32'd1);
    chk("ov_count", 32'(out_count), 32'd255);
    release_result();
    chk("ov_rel_ovf", 32'(out_ovf), 32'd0);

    // Reset mid-vector: partial state must vanish without a clock edge
    send(16'd7, 1'b0);
    send(16'd5, 1'b0);
    chk("mr_partial_sum", 32'(out_sum), 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_sum",   32'(out_sum),   32'd0);
    chk("mr_rst_count", 32'(out_count), 32'd0);
    chk("mr_rst_ready", 32'(in_ready),  32'd1);
    chk("mr_rst_valid", 32'(out_valid), 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd5, 1'b0);
    send(16'd7, 1'b1);
    chk("mr_valid", 32'(out_valid), 32'd1);
    chk("mr_sum",   32'(out_sum),   32'd12);
    chk("mr_count", 32'(out_count), 32'd2);
    release_result();

    // Negative sums; out_ready high during ACCUM must not clear anything
    out_ready = 1'b1;
    send(-16'sd7, 1'b0);
    out_ready = 1'b0;
    chk("ng_count_mid", 32'(out_count), 32'd1);
    send(-16'sd7, 1'b1);
    chk("ng_sum",   32'(out_sum),   32'h00FF_FFF2);
    chk("ng_ovf",   32'(out_ovf),   32'd0);
    chk("ng_count", 32'(out_count), 32'd2);
    release_result();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Sequential multiply-accumulate back end that consumes the 16-bit signed `product` stream of `booth_multiplier` and sums a variable-length vector of products into a wide accumulator. It emits one dot-product result per vector through a valid/ready handshake. The block sits directly downstream of the combinational multiplier. An upstream sequencer registers operand pairs and marks the final term of each vector.

## Interface
- `PROD_W`, 16: width of the signed product input, matching the multiplier's `product`.
- `ACC_W`, 24: width of the signed accumulator and result, with `ACC_W > PROD_W`.
- `CNT_W`, 8: width of the term counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_product` and `in_last` are valid this cycle.
- `in_ready`, output, 1: block accepts a term this cycle.
- `in_product`, input, `PROD_W`: signed product term.
- `in_last`, input, 1: accepted term is the final term of the current vector.
- `out_valid`, output, 1: result held on `out_sum`, `out_count` and `out_ovf`.
- `out_ready`, input, 1: consumer takes the result.
- `out_sum`, output, `ACC_W`: signed accumulated sum.
- `out_count`, output, `CNT_W`: number of terms accepted, saturating.
- `out_ovf`, output, 1: sticky flag; signed overflow occurred during this vector.

## Operation
- Two-state FSM: `ACCUM` and `HOLD`. Reset state is `ACCUM`.
- `ACCUM`:
  - `in_ready=1`, `out_valid=0`.
  - A term is accepted when `in_valid & in_ready`.
  - On accept: `acc <= acc + sext(in_product)` and `cnt <= cnt+1`. `cnt` saturates at `2^CNT_W-1`.
  - On accept, `ovf` is set if the signed add overflows `ACC_W`.
  - If `in_last` is set on the accepted term, go to `HOLD`.
- `HOLD`:
  - `in_ready=0`, `out_valid=1`.
  - `out_sum`, `out_count` and `out_ovf` are stable.
  - `in_valid` is ignored.
  - On `out_ready=1`: clear `acc`, `cnt` and `ovf`, then go to `ACCUM`.
- Overflow:
  - Detected when the operand signs are equal and the result sign differs.
  - Once set, `ovf` stays set until the result is released.
- `out_sum`, `out_count` and `out_ovf` are driven directly from registers. They read the running values while in `ACCUM` and are qualified only by `out_valid`.
- An `in_valid` term without `in_last` simply continues the vector. There is no maximum vector length.

## Timing
- Reset values: `acc=0`, `cnt=0`, `ovf=0`, state `ACCUM`. Hence `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_count=0`, `out_ovf=0`.
- Reset is asynchronous; assertion mid-vector discards all partial state immediately.
- Throughput is one term per cycle in `ACCUM`.
- Latency: `out_valid` rises on the cycle after the edge that accepts the `in_last` term.
- Release:
  - The result is released on the edge where `out_valid & out_ready` holds.
  - `in_ready` returns high the following cycle.
  - That gives one bubble cycle per vector.
- A vector of one term is legal: `in_last` on the first accepted term.
- `out_ready` has no effect while in `ACCUM`.

## Configuration
- `BOOTH_ACC_SATURATE_EN` defined:
  - On overflow, `acc` clamps to `2^(ACC_W-1)-1` (positive overflow) or `-2^(ACC_W-1)` (negative overflow).
  - Further terms continue from the clamped value.
- Undefined: `acc` wraps modulo `2^ACC_W`.
- `ovf` behaviour is identical in both builds.

## Structure
- Shared package `booth_pkg`:
  - `PROD_W`/`ACC_W`/`CNT_W` default localparams.
  - The `acc_state_t` enum (`ACCUM`, `HOLD`).
- One sub-module, `booth_sat_add`:
  - Combinational signed add of `sext(in_product)` to `acc`.
  - Outputs the sum and an overflow flag.
  - Clamping is compiled under `BOOTH_ACC_SATURATE_EN`.
- The FSM, counter and handshake live in the top module.

## Test plan
- **Multi-term vector.**
  - Stimulus: products 35, 35, -35, the last with `in_last`, back-to-back.
  - Response: `out_valid` one cycle after the third accept; `out_sum=35`, `out_count=3`, `out_ovf=0`.
- **Single-term vector.**
  - Stimulus: product -49 with `in_last`.
  - Response: `out_sum=24'hFFFFCF`, `out_count=1`.
- **Backpressure.**
  - Stimulus: hold `out_ready=0` for 5 cycles in `HOLD` while driving `in_valid=1`.
  - Response: `in_ready=0`; `out_sum` and `out_count` unchanged; no term absorbed. Then `out_ready=1` gives `in_ready=1` on the next cycle with `out_count=0`.
- **Overflow.**
  - Stimulus: 512 terms of 16384 (from -128×-128), the last with `in_last`.
  - Response with `BOOTH_ACC_SATURATE_EN`: `out_sum=24'h7FFFFF`, `out_ovf=1`, `out_count=255`.
  - Response without it: `out_sum=24'h800000`, `out_ovf=1`, `out_count=255`.
- **Reset mid-vector.**
  - Stimulus: assert `rst_n=0` asynchronously after 2 accepted terms (7, 5). Then apply a new vector 5, 7 with last.
  - Response: all outputs 0 immediately on reset; the new vector gives `out_sum=12`, `out_count=2`.
- **Negative sums.**
  - Stimulus: products -7 and 7·-1=-7, the last with `in_last`.
  - Response: `out_sum=-14` (`24'hFFFFF2`), `out_ovf=0`.
